// File: rtl/opc5ls_bus_arbiter.sv
// Shares one request/acknowledge memory port between two opc5ls cores.
// Each core is stalled through its clken until its access completes. Read data is returned on a registered per-core din.
module opc5ls_bus_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        cpu0_vpa,
  input  logic        cpu0_vda,
  input  logic        cpu0_rnw,
  input  logic [15:0] cpu0_address,
  input  logic [15:0] cpu0_dout,
  output logic [15:0] cpu0_din,
  output logic        cpu0_clken,
  input  logic        cpu1_vpa,
  input  logic        cpu1_vda,
  input  logic        cpu1_rnw,
  input  logic [15:0] cpu1_address,
  input  logic [15:0] cpu1_dout,
  output logic [15:0] cpu1_din,
  output logic        cpu1_clken,
  output logic        mem_req,
  output logic        mem_rnw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_rnw_q, mem_rnw_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] din0_q, din0_d;
  logic [15:0] din1_q, din1_d;
  logic        req0_s, req1_s, winner_s;

  assign req0_s = cpu0_vpa | cpu0_vda;
  assign req1_s = cpu1_vpa | cpu1_vda;

  // Choose the core to grant from the idle state; ties resolved by mode.
  always_comb begin
    winner_s = 1'b0;
    if (req0_s && req1_s) begin
      if (FIXED_PRIO != 0) begin
        winner_s = 1'b0;
      end else begin
        winner_s = ~last_grant_q;
      end
    end else if (req1_s) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Next-state and next-register values of the access sequencer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_rnw_d    = mem_rnw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    din0_d       = din0_q;
    din1_d       = din1_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_s || req1_s) begin
          state_d     = ST_BUSY;
          owner_d     = winner_s;
          mem_req_d   = 1'b1;
          mem_rnw_d   = winner_s ? cpu1_rnw : cpu0_rnw;
          mem_addr_d  = winner_s ? cpu1_address : cpu0_address;
          mem_wdata_d = winner_s ? cpu1_dout : cpu0_dout;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          // Only a read owned by a core may update that core's din.
          if (mem_rnw_q && owner_q) begin
            din1_d = mem_rdata;
          end else if (mem_rnw_q) begin
            din0_d = mem_rdata;
          end else begin
            din0_d = din0_q;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        last_grant_d = owner_q;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so cpu0 wins the first tie.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_rnw_q    <= 1'b1;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      din0_q       <= 16'h0000;
      din1_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      din0_q       <= din0_d;
      din1_q       <= din1_d;
    end
  end

  assign cpu0_clken = ~req0_s | ((state_q == ST_DONE) & ~owner_q);
  assign cpu1_clken = ~req1_s | ((state_q == ST_DONE) & owner_q);
  assign cpu0_din   = din0_q;
  assign cpu1_din   = din1_q;
  assign mem_req    = mem_req_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_opc5ls_bus_arbiter.sv
// Bench for opc5ls_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_opc5ls_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        cpu0_vpa = 1'b0, cpu0_vda = 1'b0, cpu0_rnw = 1'b1;
  logic [15:0] cpu0_address = 16'h0000, cpu0_dout = 16'h0000;
  logic        cpu1_vpa = 1'b0, cpu1_vda = 1'b0, cpu1_rnw = 1'b1;
  logic [15:0] cpu1_address = 16'h0000, cpu1_dout = 16'h0000;
  logic [15:0] cpu0_din, cpu1_din, fp0_din, fp1_din;
  logic        cpu0_clken, cpu1_clken, fp0_clken, fp1_clken;
  logic        mem_req, mem_rnw, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        fp_mem_req, fp_mem_rnw, fp_mem_ack;
  logic [15:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic        mem_clear = 1'b1;
  logic [3:0]  mem_wait = 4'd0;
  logic [3:0]  wcnt;
  logic [15:0] mem_arr [0:255];
  int          chk = 0;
  int          err = 0;

  always #5 clk = ~clk;

  opc5ls_bus_arbiter #(.FIXED_PRIO(0)) u_dut (
    .clk(clk), .reset_b(reset_b),
    .cpu0_vpa(cpu0_vpa), .cpu0_vda(cpu0_vda), .cpu0_rnw(cpu0_rnw), .cpu0_address(cpu0_address),
    .cpu0_dout(cpu0_dout), .cpu0_din(cpu0_din), .cpu0_clken(cpu0_clken),
    .cpu1_vpa(cpu1_vpa), .cpu1_vda(cpu1_vda), .cpu1_rnw(cpu1_rnw), .cpu1_address(cpu1_address),
    .cpu1_dout(cpu1_dout), .cpu1_din(cpu1_din), .cpu1_clken(cpu1_clken),
    .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  opc5ls_bus_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset_b(reset_b),
    .cpu0_vpa(cpu0_vpa), .cpu0_vda(cpu0_vda), .cpu0_rnw(cpu0_rnw), .cpu0_address(cpu0_address),
    .cpu0_dout(cpu0_dout), .cpu0_din(fp0_din), .cpu0_clken(fp0_clken),
    .cpu1_vpa(cpu1_vpa), .cpu1_vda(cpu1_vda), .cpu1_rnw(cpu1_rnw), .cpu1_address(cpu1_address),
    .cpu1_dout(cpu1_dout), .cpu1_din(fp1_din), .cpu1_clken(fp1_clken),
    .mem_req(fp_mem_req), .mem_rnw(fp_mem_rnw), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(fp_mem_rdata), .mem_ack(fp_mem_ack));

  // Memory model: acks after mem_wait extra cycles, reads combinationally, writes on ack.
  assign mem_ack      = mem_req && (wcnt == mem_wait);
  assign mem_rdata    = mem_arr[mem_addr[7:0]];
  assign fp_mem_ack   = fp_mem_req;
  assign fp_mem_rdata = 16'h5A5A;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 4'd1;
    else wcnt <= 4'd0;
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 8'h34) ? 16'hBEEF : {8'hC3, 8'(i)};
    end else if (mem_req && mem_ack && !mem_rnw) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic set_idle();
    cpu0_vpa = 1'b0; cpu0_vda = 1'b0; cpu0_rnw = 1'b1; cpu0_address = 16'h0000; cpu0_dout = 16'h0000;
    cpu1_vpa = 1'b0; cpu1_vda = 1'b0; cpu1_rnw = 1'b1; cpu1_address = 16'h0000; cpu1_dout = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset_b = 1'b0; mem_wait = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    chk++; if (mem_req !== 1'b0) begin err++; $display("FAIL rst_mem_req got %0h exp 0", mem_req); end
    chk++; if (mem_rnw !== 1'b1) begin err++; $display("FAIL rst_mem_rnw got %0h exp 1", mem_rnw); end
    chk++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin err++; $display("FAIL rst_addr_wdata got %h %h exp 0 0", mem_addr, mem_wdata); end
    chk++; if (cpu0_din !== 16'h0000 || cpu1_din !== 16'h0000) begin err++; $display("FAIL rst_din got %h %h exp 0 0", cpu0_din, cpu1_din); end
    chk++; if (cpu0_clken !== 1'b1 || cpu1_clken !== 1'b1) begin err++; $display("FAIL rst_clken_idle got %b%b exp 11", cpu0_clken, cpu1_clken); end
    cpu1_vpa = 1'b1;
    #1;
    chk++; if (cpu1_clken !== 1'b0 || cpu0_clken !== 1'b1) begin err++; $display("FAIL rst_clken_req got %b%b exp 10", cpu0_clken, cpu1_clken); end
    cpu1_vpa = 1'b0;
    mem_clear = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk++; if (mem_req !== 1'b0) begin err++; $display("FAIL rst_release_req got %0h exp 0", mem_req); end
  endtask

  task automatic test_single_read();
    do_reset();
    cpu0_vpa = 1'b1; cpu0_rnw = 1'b1; cpu0_address = 16'h1234;
    #1;
    chk++; if (cpu0_clken !== 1'b0) begin err++; $display("FAIL rd_clken_t got %0h exp 0", cpu0_clken); end
    @(negedge clk);
    chk++; if (mem_req !== 1'b1 || mem_addr !== 16'h1234 || mem_rnw !== 1'b1) begin err++; $display("FAIL rd_req_t1 got %0h %h %0h exp 1 1234 1", mem_req, mem_addr, mem_rnw); end
    chk++; if (cpu0_clken !== 1'b0) begin err++; $display("FAIL rd_clken_t1 got %0h exp 0", cpu0_clken); end
    @(negedge clk);
    chk++; if (mem_req !== 1'b0 || cpu0_clken !== 1'b1) begin err++; $display("FAIL rd_done_t2 got req %0h clken %0h exp 0 1", mem_req, cpu0_clken); end
    chk++; if (cpu0_din !== 16'hBEEF) begin err++; $display("FAIL rd_din got %h exp beef", cpu0_din); end
    cpu0_vpa = 1'b0;
    @(negedge clk);
    chk++; if (mem_req !== 1'b0) begin err++; $display("FAIL rd_req_after got %0h exp 0", mem_req); end
  endtask

  task automatic test_write_waits();
    do_reset();
    mem_wait = 4'd3;
    cpu1_vda = 1'b1; cpu1_rnw = 1'b0; cpu1_address = 16'h0040; cpu1_dout = 16'h00FF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk++; if (mem_req !== 1'b1 || mem_rnw !== 1'b0 || mem_wdata !== 16'h00FF || mem_addr !== 16'h0040) begin err++; $display("FAIL wr_hold[%0d] got %0h %0h %h %h exp 1 0 00ff 0040", k, mem_req, mem_rnw, mem_wdata, mem_addr); end
      chk++; if (cpu1_clken !== 1'b0) begin err++; $display("FAIL wr_stall[%0d] got %0h exp 0", k, cpu1_clken); end
    end
    @(negedge clk);
    chk++; if (mem_req !== 1'b0 || cpu1_clken !== 1'b1) begin err++; $display("FAIL wr_done got req %0h clken %0h exp 0 1", mem_req, cpu1_clken); end
    cpu1_vda = 1'b0;
    @(negedge clk);
    chk++; if (cpu1_din !== 16'h0000) begin err++; $display("FAIL wr_din_kept got %h exp 0000", cpu1_din); end
    chk++; if (mem_arr[8'h40] !== 16'h00FF) begin err++; $display("FAIL wr_mem got %h exp 00ff", mem_arr[8'h40]); end
  endtask

  task automatic test_free_run();
    do_reset();
    mem_wait = 4'd4;
    cpu1_vpa = 1'b1; cpu1_rnw = 1'b1; cpu1_address = 16'h0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk++; if (cpu0_clken !== 1'b1 || cpu1_clken !== 1'b0 || mem_req !== 1'b1) begin err++; $display("FAIL free_run[%0d] got c0 %0h c1 %0h req %0h exp 1 0 1", k, cpu0_clken, cpu1_clken, mem_req); end
    end
    @(negedge clk);
    chk++; if (cpu1_clken !== 1'b1 || cpu0_clken !== 1'b1) begin err++; $display("FAIL free_done got %b%b exp 11", cpu0_clken, cpu1_clken); end
    chk++; if (cpu1_din !== 16'hC310) begin err++; $display("FAIL free_din got %h exp c310", cpu1_din); end
    cpu1_vpa = 1'b0;
  endtask

  task automatic test_round_robin();
    logic prev_m, prev_f, exp_o;
    int   last_t, n_gr;
    do_reset();
    cpu0_vpa = 1'b1; cpu0_rnw = 1'b1; cpu0_address = 16'h0011;
    cpu1_vda = 1'b1; cpu1_rnw = 1'b1; cpu1_address = 16'h0022;
    prev_m = 1'b0; prev_f = 1'b0; exp_o = 1'b0; last_t = -1; n_gr = 0;
    for (int cyc = 0; cyc < 19; cyc++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && !prev_m) begin
        chk++; if (mem_addr !== (exp_o ? 16'h0022 : 16'h0011)) begin err++; $display("FAIL rr_grant[%0d] got %h exp cpu%0d", n_gr, mem_addr, exp_o); end
        if (last_t >= 0) begin
          chk++; if (cyc - last_t != 3) begin err++; $display("FAIL rr_period got %0d exp 3", cyc - last_t); end
        end
        last_t = cyc; exp_o = ~exp_o; n_gr++;
      end
      if (fp_mem_req === 1'b1 && !prev_f) begin
        chk++; if (fp_mem_addr !== 16'h0011) begin err++; $display("FAIL fp_grant got %h exp 0011", fp_mem_addr); end
      end
      prev_m = mem_req; prev_f = fp_mem_req;
    end
    chk++; if (n_gr < 6) begin err++; $display("FAIL rr_count got %0d exp >=6", n_gr); end
    do_reset();
    cpu1_vda = 1'b1; cpu1_rnw = 1'b1; cpu1_address = 16'h0022;
    @(negedge clk);
    chk++; if (fp_mem_req !== 1'b1 || fp_mem_addr !== 16'h0022) begin err++; $display("FAIL fp_alone got %0h %h exp 1 0022", fp_mem_req, fp_mem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cpu0_vpa = 1'b1; cpu0_rnw = 1'b1; cpu0_address = 16'h0005;
    repeat (2) @(negedge clk);
    cpu0_vpa = 1'b0;
    @(negedge clk);
    mem_wait = 4'd10;
    cpu1_vda = 1'b1; cpu1_rnw = 1'b1; cpu1_address = 16'h0006;
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    #1;
    chk++; if (mem_req !== 1'b0) begin err++; $display("FAIL mid_req_drop got %0h exp 0", mem_req); end
    chk++; if (cpu1_clken !== 1'b0 || cpu0_clken !== 1'b1) begin err++; $display("FAIL mid_clken got %b%b exp 10", cpu0_clken, cpu1_clken); end
    @(negedge clk);
    reset_b = 1'b1; mem_wait = 4'd0;
    cpu0_vpa = 1'b1; cpu0_address = 16'h0007;
    @(negedge clk);
    chk++; if (mem_req !== 1'b1 || mem_addr !== 16'h0007) begin err++; $display("FAIL mid_tie got %0h %h exp 1 0007", mem_req, mem_addr); end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [0:15];
    logic        act [0:1];
    logic        rnw_m [0:1];
    logic [1:0]  vsel [0:1];
    logic [15:0] addr_m [0:1];
    logic [15:0] dout_m [0:1];
    logic        busy, done_next, done_now, grant_next, owner, win, last, exp_ck, ck;
    logic [15:0] g_addr, g_wdata, dn;
    logic        g_rnw;
    int          ncomp;
    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_arr[i];
    for (int n = 0; n < 2; n++) begin act[n] = 1'b0; rnw_m[n] = 1'b1; vsel[n] = 2'd0; addr_m[n] = 16'h0000; dout_m[n] = 16'h0000; end
    busy = 1'b0; done_next = 1'b0; grant_next = 1'b0; owner = 1'b0; win = 1'b0; last = 1'b1;
    g_addr = 16'h0000; g_wdata = 16'h0000; g_rnw = 1'b1; ncomp = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (grant_next) begin busy = 1'b1; owner = win; grant_next = 1'b0; end
      if (busy) begin
        chk++; if (mem_req !== 1'b1 || mem_addr !== g_addr || mem_rnw !== g_rnw || mem_wdata !== g_wdata) begin err++; $display("FAIL rnd_bus@%0d got %0h %h %0h %h exp 1 %h %0h %h", cyc, mem_req, mem_addr, mem_rnw, mem_wdata, g_addr, g_rnw, g_wdata); end
      end else begin
        chk++; if (mem_req !== 1'b0) begin err++; $display("FAIL rnd_idle@%0d got %0h exp 0", cyc, mem_req); end
      end
      done_now = done_next; done_next = 1'b0;
      if (busy && mem_ack) begin busy = 1'b0; done_next = 1'b1; end
      for (int n = 0; n < 2; n++) begin
        ck = (n == 1) ? cpu1_clken : cpu0_clken;
        dn = (n == 1) ? cpu1_din : cpu0_din;
        exp_ck = !act[n] || (done_now && owner == n[0]);
        chk++; if (ck !== exp_ck) begin err++; $display("FAIL rnd_clken%0d@%0d got %0h exp %0h", n, cyc, ck, exp_ck); end
        if (act[n] && exp_ck) begin
          if (rnw_m[n]) begin
            chk++; if (dn !== ref_mem[addr_m[n][3:0]]) begin err++; $display("FAIL rnd_din%0d@%0d got %h exp %h", n, cyc, dn, ref_mem[addr_m[n][3:0]]); end
          end else begin
            ref_mem[addr_m[n][3:0]] = dout_m[n];
          end
          last = n[0]; act[n] = 1'b0; ncomp++;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 2) != 0) begin
          act[n] = 1'b1; rnw_m[n] = 1'($urandom_range(0, 1)); vsel[n] = 2'($urandom_range(1, 3));
          addr_m[n] = 16'($urandom_range(0, 15)); dout_m[n] = 16'($urandom);
        end else if (!act[n]) begin
          vsel[n] = 2'd0;
        end
      end
      cpu0_vpa = vsel[0][0]; cpu0_vda = vsel[0][1]; cpu0_rnw = rnw_m[0]; cpu0_address = addr_m[0]; cpu0_dout = dout_m[0];
      cpu1_vpa = vsel[1][0]; cpu1_vda = vsel[1][1]; cpu1_rnw = rnw_m[1]; cpu1_address = addr_m[1]; cpu1_dout = dout_m[1];
      if (!busy && !done_next && !done_now && (act[0] || act[1])) begin
        win = (act[0] && act[1]) ? ~last : act[1];
        g_addr = addr_m[win]; g_rnw = rnw_m[win]; g_wdata = dout_m[win];
        grant_next = 1'b1;
        mem_wait = 4'($urandom_range(0, 3));
      end
    end
    chk++; if (ncomp < 50) begin err++; $display("FAIL rnd_progress got %0d exp >=50", ncomp); end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_waits();
    test_free_run();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
